// File: rtl/ppu_mem_arbiter.sv
// PPU memory-port sequencer: shares the single 8-bit port between render fetches
// and the CPU PPUDATA path (address latch, buffered reads, auto-increment).
module ppu_mem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rend_req,
  input  logic [15:0] rend_addr,
  output logic        rend_ack,
  output logic [7:0]  rend_rdata,
  output logic        rend_valid,
  input  logic        cpu_addr_wr,
  input  logic        cpu_data_wr,
  input  logic        cpu_data_rd,
  input  logic        cpu_status_rd,
  input  logic [7:0]  cpu_wdata,
  input  logic        inc32,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_busy,
  output logic [13:0] vaddr,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] SLIM = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE, R_ISSUE, R_DATA, C_RD_ISSUE, C_RD_DATA, C_WR
  } state_t;

  state_t        state, state_n;
  logic          w, pending, op_rd;
  logic [13:0]   op_addr;
  logic [7:0]    op_wdata, rd_buf;
  logic [CW-1:0] starve_cnt;
  logic          at_decision, grant_cpu, grant_rend, accept, addr_wr_eff;

  // Handshake: rend_req is held until rend_ack; rend_valid pulses two cycles after
  // rend_ack. CPU pulses are single-cycle and a data op is taken only when !cpu_busy.
  assign cpu_busy    = pending | (state == C_RD_ISSUE) | (state == C_RD_DATA) | (state == C_WR);
  assign accept      = (cpu_data_wr | cpu_data_rd) & ~cpu_busy;
  assign addr_wr_eff = cpu_addr_wr & ~cpu_status_rd;

  // Decisions happen in IDLE and in the final cycle of each access: no bubbles.
  assign at_decision = (state == IDLE) | (state == R_DATA) | (state == C_RD_DATA) | (state == C_WR);
  assign grant_cpu   = at_decision & pending & ((starve_cnt == SLIM) | ~rend_req);
  assign grant_rend  = at_decision & ~grant_cpu & rend_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    rend_ack  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    case (state)
      R_ISSUE: begin
        mem_re   = 1'b1;
        mem_addr = rend_addr;
        rend_ack = 1'b1;
        state_n  = R_DATA;
      end
      C_RD_ISSUE: begin
        mem_re   = 1'b1;
        mem_addr = {2'b00, op_addr};
        state_n  = C_RD_DATA;
      end
      C_WR: begin
        mem_we    = 1'b1;
        mem_addr  = {2'b00, op_addr};
        mem_wdata = op_wdata;
      end
      default: ;
    endcase
    if (at_decision) begin
      if (grant_cpu)       state_n = op_rd ? C_RD_ISSUE : C_WR;
      else if (grant_rend) state_n = R_ISSUE;
      else                 state_n = IDLE;
    end
  end

  // Address register, write toggle, op capture and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vaddr      <= '0;
      w          <= 1'b0;
      op_addr    <= '0;
      op_rd      <= 1'b0;
      op_wdata   <= '0;
      pending    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (cpu_status_rd)    w <= 1'b0;
      else if (cpu_addr_wr) w <= ~w;

      if (addr_wr_eff && !w)  vaddr[13:8] <= cpu_wdata[5:0];
      else if (addr_wr_eff)   vaddr[7:0]  <= cpu_wdata;
      else if (accept)        vaddr       <= vaddr + (inc32 ? 14'd32 : 14'd1);

      if (accept) begin
        op_addr  <= vaddr;
        op_rd    <= cpu_data_rd;
        op_wdata <= cpu_wdata;
      end

      if (accept)         pending <= 1'b1;
      else if (grant_cpu) pending <= 1'b0;

      if (!pending || grant_cpu)               starve_cnt <= '0;
      else if (grant_rend && starve_cnt != SLIM) starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Read data return paths: render byte, read buffer and CPU-visible byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rend_rdata <= '0;
      rend_valid <= 1'b0;
      rd_buf     <= '0;
      cpu_rdata  <= '0;
    end else begin
      rend_valid <= (state == R_DATA);
      if (state == R_DATA) rend_rdata <= mem_rdata;
      if (accept && cpu_data_rd && vaddr[13:8] != 6'h3F) cpu_rdata <= rd_buf;
      if (state == C_RD_DATA) begin
        rd_buf <= mem_rdata;
        // Palette reads bypass the buffer delay.
        if (op_addr[13:8] == 6'h3F) cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Bench for ppu_mem_arbiter: transaction-level model with memory responder,
// per-cycle scoreboard and directed scenarios with literal expectations.
module tb_ppu_mem_arbiter;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rend_req, cpu_addr_wr, cpu_data_wr, cpu_data_rd, cpu_status_rd, inc32;
  logic [15:0] rend_addr;
  logic [7:0]  cpu_wdata;
  logic        rend_ack, rend_valid, cpu_busy, mem_re, mem_we;
  logic [7:0]  rend_rdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [13:0] vaddr;
  logic [15:0] mem_addr;

  ppu_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rend_req(rend_req), .rend_addr(rend_addr), .rend_ack(rend_ack),
    .rend_rdata(rend_rdata), .rend_valid(rend_valid),
    .cpu_addr_wr(cpu_addr_wr), .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
    .cpu_status_rd(cpu_status_rd), .cpu_wdata(cpu_wdata), .inc32(inc32),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .vaddr(vaddr),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents and model state
  logic [7:0] mem [0:65535];
  typedef struct { logic [13:0] addr; logic rd; logic [7:0] wdata; } cpu_op_t;
  cpu_op_t     cpu_q[$];
  cpu_op_t     cur_op;
  logic [7:0]  exp_q[$];
  int          due_q[$];
  int          cyc;
  logic [13:0] m_vaddr;
  logic        m_w, m_busy, ret_stage, ret_pal;
  logic [7:0]  m_rd_buf, m_cpu_rdata, ret_byte;
  logic        m_accept;
  logic        s_re, s_we, ev_cpu_wr, ev_cpu_rd, prev_pend, exp_v;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic [13:0] ev_addr;
  int          starve_seen, last_starve;

  assign m_accept = (cpu_data_wr | cpu_data_rd) & ~m_busy;

  // Model: advances on each clock from the sampled inputs and observed accesses.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc         <= 0;
      m_vaddr     <= '0;
      m_w         <= 1'b0;
      m_busy      <= 1'b0;
      m_rd_buf    <= '0;
      m_cpu_rdata <= '0;
      ret_stage   <= 1'b0;
      ret_pal     <= 1'b0;
      ret_byte    <= '0;
      mem_rdata   <= '0;
    end else begin
      cyc <= cyc + 1;
      if (s_re) mem_rdata <= mem[s_addr];
      ret_stage <= ev_cpu_rd;
      if (ev_cpu_rd) begin
        ret_byte <= mem[{2'b00, ev_addr}];
        ret_pal  <= (ev_addr[13:8] == 6'h3F);
      end
      if (ret_stage) begin
        m_rd_buf <= ret_byte;
        if (ret_pal) m_cpu_rdata <= ret_byte;
        m_busy <= 1'b0;
      end
      if (ev_cpu_wr) m_busy <= 1'b0;
      if (m_accept) begin
        cpu_q.push_back('{m_vaddr, cpu_data_rd, cpu_wdata});
        m_busy <= 1'b1;
        if (cpu_data_rd && m_vaddr[13:8] != 6'h3F) m_cpu_rdata <= m_rd_buf;
      end
      if (cpu_status_rd)    m_w <= 1'b0;
      else if (cpu_addr_wr) m_w <= ~m_w;
      if (cpu_addr_wr && !cpu_status_rd)
        m_vaddr <= m_w ? {m_vaddr[13:8], cpu_wdata} : {cpu_wdata[5:0], m_vaddr[7:0]};
      else if (m_accept)
        m_vaddr <= 14'((int'(m_vaddr) + (inc32 ? 32 : 1)) % 16384);
    end
  end

  // Scoreboard: compares DUT outputs with the model every cycle.
  always @(negedge clk) begin
    s_re = 1'b0; s_we = 1'b0; ev_cpu_wr = 1'b0; ev_cpu_rd = 1'b0;
    if (!rst_n) begin
      cpu_q.delete(); exp_q.delete(); due_q.delete();
      starve_seen = 0; prev_pend = 1'b0;
      check("rst_ctl", {rend_ack, rend_valid, mem_re, mem_we, cpu_busy, cpu_rdata, rend_rdata}, 0);
      check("rst_addr", {mem_addr, mem_wdata}, 0);
      check("rst_vaddr", vaddr, 0);
    end else begin
      check("vaddr", vaddr, m_vaddr);
      check("cpu_rdata", cpu_rdata, m_cpu_rdata);
      check("cpu_busy", cpu_busy, m_busy);
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        void'(due_q.pop_front()); void'(exp_q.pop_front());
      end
      exp_v = (due_q.size() > 0 && due_q[0] == cyc);
      check("rend_valid", rend_valid, exp_v);
      if (exp_v) begin
        check("rend_rdata", rend_rdata, exp_q[0]);
        void'(due_q.pop_front()); void'(exp_q.pop_front());
      end
      if (rend_ack) begin
        check("rend_ack_re", {mem_re, mem_we}, 2'b10);
        check("rend_mem_addr", mem_addr, rend_addr);
        exp_q.push_back(mem[rend_addr]);
        due_q.push_back(cyc + 2);
        if (prev_pend) starve_seen++;
      end else if (mem_re || mem_we) begin
        if (cpu_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_access: got access at %0h expected none", mem_addr);
        end else begin
          cur_op = cpu_q.pop_front();
          check("cpu_op_kind", {mem_re, mem_we}, {cur_op.rd, ~cur_op.rd});
          check("cpu_mem_addr", mem_addr, {2'b00, cur_op.addr});
          if (!cur_op.rd) begin
            check("cpu_wdata", mem_wdata, cur_op.wdata);
            mem[mem_addr] = mem_wdata;
          end
          check("starve_bound", starve_seen <= STARVE_LIMIT, 1);
          last_starve = starve_seen;
          starve_seen = 0;
          ev_cpu_wr = mem_we; ev_cpu_rd = mem_re; ev_addr = cur_op.addr;
        end
      end
      prev_pend = (cpu_q.size() > 0);
      s_re = mem_re; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    end
  end

  // Driver tasks
  task automatic addr_wr(input logic [7:0] d);
    @(posedge clk); #1; cpu_addr_wr = 1'b1; cpu_wdata = d;
    @(posedge clk); #1; cpu_addr_wr = 1'b0;
  endtask

  task automatic status_rd();
    @(posedge clk); #1; cpu_status_rd = 1'b1;
    @(posedge clk); #1; cpu_status_rd = 1'b0;
  endtask

  task automatic data_op(input logic rd, input logic [7:0] d);
    @(posedge clk); #1; cpu_data_rd = rd; cpu_data_wr = ~rd; cpu_wdata = d;
    @(posedge clk); #1; cpu_data_rd = 1'b0; cpu_data_wr = 1'b0;
  endtask

  // which: 0 rend_ack, 1 mem_we, 2 mem_re, 3 not busy
  task automatic wait_sig(input int which, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #1;
      case (which)
        0: hit = rend_ack;
        1: hit = mem_we;
        2: hit = mem_re;
        default: hit = ~cpu_busy;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  int t1;

  initial begin
    rend_req = 0; rend_addr = 0; cpu_addr_wr = 0; cpu_data_wr = 0; cpu_data_rd = 0;
    cpu_status_rd = 0; cpu_wdata = 0; inc32 = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h5A; mem[16'h0018] = 8'hC3; mem[16'h3F05] = 8'h1C; mem[16'h0040] = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    check("init_vaddr", vaddr, 14'h0000);
    check("init_busy", cpu_busy, 0);
    rst_n = 1'b1;

    // Address latch and write toggle
    addr_wr(8'h21); addr_wr(8'h08);
    check("latch_2108", vaddr, 14'h2108);
    status_rd(); addr_wr(8'h3F);
    check("latch_hi_3f", vaddr, 14'h3F08);
    addr_wr(8'h00);
    check("latch_lo_after_hi", vaddr, 14'h3F00);
    @(posedge clk); #1; cpu_status_rd = 1; cpu_addr_wr = 1; cpu_wdata = 8'h12;
    @(posedge clk); #1; cpu_status_rd = 0; cpu_addr_wr = 0;
    check("status_beats_addr", vaddr, 14'h3F00);
    addr_wr(8'h20); addr_wr(8'h00);
    check("latch_2000", vaddr, 14'h2000);

    // Write, then a dropped op while busy
    data_op(1'b0, 8'hAB);
    check("wr_inc", vaddr, 14'h2001);
    data_op(1'b0, 8'hEE);
    check("drop_no_inc", vaddr, 14'h2001);
    wait_sig(3, 100, "wr_idle");
    check("wr_mem", mem[16'h2000], 8'hAB);

    // Buffered reads
    addr_wr(8'h20); addr_wr(8'h00);
    data_op(1'b1, 8'h00); wait_sig(3, 100, "rd1_idle");
    check("rd1_stale", cpu_rdata, 8'h00);
    data_op(1'b1, 8'h00); wait_sig(3, 100, "rd2_idle");
    check("rd2_buffered", cpu_rdata, 8'hAB);
    check("rd2_vaddr", vaddr, 14'h2002);

    // Palette read
    addr_wr(8'h3F); addr_wr(8'h05);
    data_op(1'b1, 8'h00);
    wait_sig(2, 20, "pal_re");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pal_rdata", cpu_rdata, 8'h1C);
    check("pal_busy_low", cpu_busy, 0);
    addr_wr(8'h20); addr_wr(8'h00);
    data_op(1'b1, 8'h00); wait_sig(3, 100, "pal_buf_idle");
    check("pal_rd_buf", cpu_rdata, 8'h1C);

    // Render back-to-back
    rend_addr = 16'h0010; rend_req = 1'b1;
    wait_sig(0, 20, "b2b_ack1");
    t1 = cyc;
    @(posedge clk); #1; rend_addr = 16'h0018;
    @(posedge clk); #1;
    check("b2b_ack2_cycle", {rend_ack, 32'(cyc - t1)}, {1'b1, 32'd2});
    check("b2b_addr2", mem_addr, 16'h0018);
    check("b2b_valid1", {rend_valid, rend_rdata}, {1'b1, 8'h5A});
    rend_req = 1'b0;
    @(posedge clk); #1;
    check("b2b_gap", rend_valid, 0);
    @(posedge clk); #1;
    check("b2b_valid2", {rend_valid, rend_rdata}, {1'b1, 8'hC3});
    repeat (2) @(posedge clk);

    // Starvation: continuous render with CPU writes waiting
    addr_wr(8'h01); addr_wr(8'h00);
    rend_addr = 16'h0040; rend_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      repeat (3) @(posedge clk);
      data_op(1'b0, 8'h98 + 8'(k));
      wait_sig(1, 60, "starve_we");
      @(negedge clk); #1;
      check("starve_grants", last_starve, STARVE_LIMIT);
      @(posedge clk); #1;
      check("render_resumes", rend_ack, 1);
    end
    rend_req = 1'b0;
    repeat (4) @(posedge clk);
    check("starve_mem", mem[16'h0101], 8'h99);

    // vaddr wrap, +32 then +1
    addr_wr(8'h3F); addr_wr(8'hF0);
    inc32 = 1'b1;
    data_op(1'b1, 8'h00);
    check("wrap_inc32", vaddr, 14'h0010);
    inc32 = 1'b0;
    wait_sig(3, 100, "wrap32_idle");
    addr_wr(8'h3F); addr_wr(8'hFF);
    data_op(1'b0, 8'h55);
    check("wrap_inc1", vaddr, 14'h0000);
    wait_sig(3, 100, "wrap1_idle");

    // Reset during C_WR
    addr_wr(8'h23); addr_wr(8'h45);
    data_op(1'b0, 8'h66);
    wait_sig(1, 20, "mid_we");
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", {mem_we, mem_re, cpu_busy, rend_ack, rend_valid}, 0);
    check("mid_rst_addr", {mem_addr, mem_wdata}, 0);
    check("mid_rst_vaddr", vaddr, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_idle", {mem_we, mem_re, cpu_busy}, 0);
    check("post_rst_nowrite", mem[16'h2345], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ppu_mem_arbiter.md
# ppu_mem_arbiter

Sequencer and arbiter for the PPU's single 8-bit memory port. It shares the port between two requesters: the render fetch engine and the CPU-side PPUDATA path. The CPU-side path includes the two-write address latch, buffered reads and address auto-increment. It drives raw 16-bit PPU addresses into the PPU address decoder/mirroring stage, which feeds the VRAM/CHR/palette storage.

## Interface
Parameters:
- STARVE_LIMIT, 8: consecutive render grants allowed while a CPU op waits; the next grant goes to the CPU.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rend_req  in  1  render fetch request; hold until rend_ack.
- rend_addr  in  16  render fetch address.
- rend_ack  out  1  one-cycle pulse in the issue cycle of a render access.
- rend_rdata  out  8  fetched byte.
- rend_valid  out  1  one-cycle pulse; rend_rdata is valid.
- cpu_addr_wr  in  1  one-cycle pulse: CPU write to the address register ($2006).
- cpu_data_wr  in  1  one-cycle pulse: CPU write to PPUDATA ($2007).
- cpu_data_rd  in  1  one-cycle pulse: CPU read of PPUDATA ($2007).
- cpu_status_rd  in  1  one-cycle pulse: status read; clears the write toggle.
- cpu_wdata  in  8  CPU write byte.
- inc32  in  1  address increment select: 0 adds 1, 1 adds 32.
- cpu_rdata  out  8  byte returned to the CPU.
- cpu_busy  out  1  a CPU data op is pending or in flight.
- vaddr  out  14  current VRAM address register.
- mem_addr  out  16  address to the decoder (render address, or {2'b00, op_addr}).
- mem_re  out  1  memory read strobe; mem_rdata is valid the following cycle.
- mem_we  out  1  memory write strobe; data is written on this edge.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  memory read data.

## Operation
- Address latch, write toggle w:
  - cpu_addr_wr with w=0: vaddr[13:8] <= cpu_wdata[5:0]; w <= 1.
  - cpu_addr_wr with w=1: vaddr[7:0] <= cpu_wdata; w <= 0.
  - cpu_status_rd: w <= 0. If cpu_status_rd and cpu_addr_wr arrive in the same cycle, the status clear wins and the address write is ignored.
- CPU data op acceptance (only when cpu_busy=0):
  - Capture op_addr <= vaddr, op type, and op_wdata <= cpu_wdata; set pending.
  - Same cycle: vaddr <= (vaddr + (inc32 ? 32 : 1)) mod 2^14.
  - A data op that arrives while busy is dropped, with no increment.
  - If cpu_addr_wr arrives in the same cycle as a data op, the address write wins over the increment. The data op still uses the pre-update vaddr.
- Buffered read:
  - On acceptance, cpu_rdata <= rd_buf unless op_addr[13:8]==6'h3F.
  - On data return, rd_buf <= mem_rdata.
  - For palette addresses (op_addr[13:8]==6'h3F), cpu_rdata <= mem_rdata on data return instead. rd_buf is also loaded with the palette byte.
- FSM states: IDLE, R_ISSUE, R_DATA, C_RD_ISSUE, C_RD_DATA, C_WR.
  - Grant decision is made in IDLE and in the last cycle of every access (R_DATA, C_RD_DATA, C_WR), so there is no bubble between accesses.
  - Grant order: if pending and (starve_cnt==STARVE_LIMIT or !rend_req), grant the CPU. Otherwise, if rend_req, grant render. Otherwise go to IDLE.
  - R_ISSUE: mem_re=1, mem_addr=rend_addr, rend_ack=1 → R_DATA.
  - R_DATA: rend_rdata <= mem_rdata, rend_valid=1 next cycle → grant decision.
  - C_RD_ISSUE: mem_re=1, mem_addr=op_addr → C_RD_DATA (buffer/cpu_rdata update per above); pending cleared.
  - C_WR: mem_we=1, mem_wdata=op_wdata, mem_addr=op_addr; pending cleared → grant decision.
- starve_cnt: increments on each render grant while pending=1, saturating at STARVE_LIMIT. Clears to 0 on each CPU grant and whenever pending=0.
- cpu_busy = pending or state in {C_RD_ISSUE, C_RD_DATA, C_WR}.

## Timing
- Reset: all outputs 0; vaddr=0, w=0, rd_buf=0, starve_cnt=0, pending=0, state=IDLE. Reset asserted mid-access aborts it with no write and no rend_valid.
- Render read: rend_ack at cycle T (request seen in IDLE at T-1 or earlier), mem_rdata at T+1, rend_valid at T+2. Sustained throughput is one access per 2 cycles.
- CPU write: accepted at A; mem_we no earlier than A+1; cpu_busy falls the cycle after C_WR.
- CPU read: mem_re no earlier than A+1; palette cpu_rdata valid at the mem_re cycle +2; cpu_busy falls in that same cycle.
- Worst-case CPU wait under continuous rend_req: 2*STARVE_LIMIT cycles after the current access completes.
- vaddr wraps 3FFF → 0000 (+1) and 3FE0..3FFF → 0000..001F (+32).

## Test plan
- Address latch: cpu_addr_wr 0x21 then 0x08 → vaddr=0x2108. Then status_rd, then cpu_addr_wr 0x3F → vaddr[13:8]=0x3F, w=1.
- Write then buffered read: vaddr=0x2000, inc32=0, write 0xAB → mem_we with mem_addr=0x2000, data 0xAB; vaddr=0x2001. Set vaddr=0x2000 and read twice → first cpu_rdata is the stale rd_buf (0 after reset), second is 0xAB.
- Palette read: memory at 0x3F05 holds 0x1C, vaddr=0x3F05 → cpu_rdata=0x1C two cycles after mem_re; rd_buf=0x1C.
- Render back-to-back: rend_req held with addrs 0x0010, 0x0018 → rend_ack at T and T+2, rend_valid at T+2 and T+4 with the correct bytes.
- Starvation: rend_req held, CPU write pending, STARVE_LIMIT=8 → exactly 8 render grants, then C_WR, then render resumes; starve_cnt returns to 0.
- Wrap and reset: vaddr=0x3FF0, inc32=1, read → vaddr=0x0010. Assert rst_n low during C_WR → no mem_we and all outputs 0.
